wta_round_sched: RTL

- Sequences a winner-take-all competition across N_CH 4-bit channels delivered serially over a valid/ready stream.
- Tracks the running maximum and resolves one winner per round.
- Applies per-channel refractory inhibition so that a recent winner is excluded from the next REFRAC rounds.
- Sits between the channel sampling front-end and the winner output register bank.

---
 rtl/wta_round_sched.sv | 127 ++++++++++++
 1 files changed

// File: rtl/wta_round_sched.sv
// Winner-take-all round scheduler: serial channel collection, running max,
// and per-channel refractory inhibition of recent winners.
module wta_round_sched #(
    parameter int N_CH   = 8,
    parameter int W      = 4,
    parameter int IDX_W  = 3,
    parameter int REFRAC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             win_valid,
    output logic [IDX_W-1:0] win_idx,
    output logic [W-1:0]     win_val
);

    typedef enum logic [1:0] {IDLE, COLLECT, RESOLVE} state_t;

    localparam logic [2:0]     REFRAC_C = 3'(REFRAC);
    localparam logic [IDX_W:0] LAST     = (IDX_W+1)'(N_CH - 1);

    state_t           state, state_nx;
    logic [IDX_W:0]   beat;
    logic             best_valid;
    logic [IDX_W-1:0] best_idx;
    logic [W-1:0]     best_val;
    logic [2:0]       refr_cnt [N_CH];
    logic             accept, eligible, take, commit, launch;

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        busy     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !abort) state_nx = COLLECT;
            end
            COLLECT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (abort)
                    state_nx = IDLE;
                else if (in_valid && beat == LAST)
                    state_nx = RESOLVE;
            end
            RESOLVE: begin
                busy     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Eligibility is looked up by loop so a beat count past N_CH never indexes out of range.
    always_comb begin
        eligible = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (beat == (IDX_W+1)'(k)) eligible = (refr_cnt[k] == 3'd0);
        end
    end

    assign accept = in_ready && in_valid;
    assign take   = accept && eligible && (!best_valid || in_data >= best_val);
    assign commit = (state == RESOLVE) && !abort;
    assign launch = (state == IDLE) && (state_nx == COLLECT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat       <= '0;
            best_valid <= 1'b0;
            best_idx   <= '0;
            best_val   <= '0;
        end else if (launch) begin
            beat       <= '0;
            best_valid <= 1'b0;
        end else if (accept) begin
            beat <= beat + 1'b1;
            if (take) begin
                best_valid <= 1'b1;
                best_idx   <= beat[IDX_W-1:0];
                best_val   <= in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done      <= 1'b0;
            win_valid <= 1'b0;
            win_idx   <= '0;
            win_val   <= '0;
        end else begin
            done <= commit;
            if (commit) begin
                win_valid <= best_valid;
                win_idx   <= best_valid ? best_idx : '0;
                win_val   <= best_valid ? best_val : '0;
            end
        end
    end

    // A fresh winner reload overrides the decrement so it sits out exactly REFRAC rounds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_CH; k++) refr_cnt[k] <= 3'd0;
        end else if (commit) begin
            for (int k = 0; k < N_CH; k++) begin
                if (best_valid && REFRAC > 0 && best_idx == IDX_W'(k))
                    refr_cnt[k] <= REFRAC_C;
                else if (refr_cnt[k] != 3'd0)
                    refr_cnt[k] <= refr_cnt[k] - 3'd1;
            end
        end
    end

endmodule
